// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : BUSY (request on bus), HOLD (word parked in hold buffer),
//                   DISCARD (outstanding transfer belongs to a flushed path)
//   NOP_INST      : addi x0,x0,0, injected into IF/ID whenever it is invalid
//   word_align    : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    BUSY    = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Single-outstanding instruction-memory bus.
//   req   : master -> slave, held high with a stable addr until ack
//   addr  : master -> slave, word-aligned fetch address
//   ack   : slave -> master, transfer completes on req && ack
//   rdata : slave -> master, instruction word, valid with ack
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: owns the PC, drives the imem bus, and feeds the
// IF/ID register. Honours hazard_stall (hold), data_mem_wait (freeze) and
// redirect (flush + new PC).
// Ports:
//   clk, rst           : core clock, asynchronous active-high reset
//   i_hazard_stall     : ID hold, keep IF/ID and PC
//   i_data_mem_wait    : MEM stall, whole pipeline frozen
//   i_redirect_valid   : flush IF/ID and refetch from i_redirect_pc
//   i_redirect_pc      : redirect target (bits [1:0] ignored for fetch)
//   imem               : instruction-memory bus (master side)
//   o_inst_mem_wait    : fetch not ready, pipeline must freeze
//   o_if_pc/o_if_inst  : IF/ID payload (NOP when invalid)
//   o_if_valid         : o_if_inst is a real instruction
// ---------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_hazard_stall,
  input  logic               i_data_mem_wait,
  input  logic               i_redirect_valid,
  input  logic [31:0]        i_redirect_pc,
  if_fetch_unit_if.master    imem,
  output logic               o_inst_mem_wait,
  output logic [31:0]        o_if_pc,
  output logic [31:0]        o_if_inst,
  output logic               o_if_valid
);

  fetch_state_t r_state, w_state_nx;
  logic [31:0]  r_pc, w_pc_nx;
  logic [31:0]  r_hold, w_hold_nx;
  logic [31:0]  r_old_addr, w_old_addr_nx;   // address of a transfer being discarded
  logic [31:0]  r_if_pc, w_if_pc_nx;
  logic [31:0]  r_if_inst, w_if_inst_nx;
  logic         r_if_valid, w_if_valid_nx;
  logic         w_req, w_imw;
  logic         w_adv, w_redir;

  assign w_adv   = !i_hazard_stall && !i_data_mem_wait;
  // The redirect source keeps its request up while the pipeline is frozen.
  assign w_redir = i_redirect_valid && !i_data_mem_wait;

  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_hold_nx     = r_hold;
    w_old_addr_nx = r_old_addr;
    w_if_pc_nx    = r_if_pc;
    w_if_inst_nx  = r_if_inst;
    w_if_valid_nx = r_if_valid;
    w_req         = 1'b0;
    w_imw         = 1'b0;

    unique case (r_state)
      BUSY: begin
        w_req = 1'b1;
        w_imw = !imem.ack;
        if (imem.ack && w_adv) begin
          w_if_pc_nx    = r_pc;
          w_if_inst_nx  = imem.rdata;
          w_if_valid_nx = 1'b1;
          w_pc_nx       = r_pc + 32'd4;
        end else if (imem.ack) begin
          // Pipeline can't take it yet; park the word so the bus is released.
          w_hold_nx  = imem.rdata;
          w_state_nx = HOLD;
        end
      end
      HOLD: begin
        if (w_adv) begin
          w_if_pc_nx    = r_pc;
          w_if_inst_nx  = r_hold;
          w_if_valid_nx = 1'b1;
          w_pc_nx       = r_pc + 32'd4;
          w_state_nx    = BUSY;
        end
      end
      DISCARD: begin
        w_req = 1'b1;
        w_imw = 1'b1;
        if (imem.ack) w_state_nx = BUSY;
      end
      default: w_state_nx = BUSY;
    endcase

    // Redirect overrides every state action. A transfer still in flight
    // cannot be aborted, so it is drained in DISCARD with its old address.
    if (w_redir) begin
      w_pc_nx       = word_align(i_redirect_pc);
      w_if_pc_nx    = i_redirect_pc;
      w_if_inst_nx  = NOP_INST;
      w_if_valid_nx = 1'b0;
      if (r_state != HOLD && !imem.ack) begin
        w_state_nx = DISCARD;
        if (r_state == BUSY) w_old_addr_nx = word_align(r_pc);
      end else begin
        w_state_nx = BUSY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BUSY;
      r_pc       <= RESET_PC;
      r_hold     <= NOP_INST;
      r_old_addr <= word_align(RESET_PC);
      r_if_pc    <= RESET_PC;
      r_if_inst  <= NOP_INST;
      r_if_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_hold     <= w_hold_nx;
      r_old_addr <= w_old_addr_nx;
      r_if_pc    <= w_if_pc_nx;
      r_if_inst  <= w_if_inst_nx;
      r_if_valid <= w_if_valid_nx;
    end
  end

  // req is gated by rst so the bus drops immediately on an asynchronous reset.
  assign imem.req        = w_req && !rst;
  assign imem.addr       = (r_state == DISCARD) ? r_old_addr : word_align(r_pc);
  assign o_inst_mem_wait = w_imw;
  assign o_if_pc         = r_if_pc;
  assign o_if_inst       = r_if_inst;
  assign o_if_valid      = r_if_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Transaction-level model of the fetch stage: a next-fetch PC, an optional
// parked word, an optional dead (flushed) transfer, and the IF/ID contents.
// Memory contents are a fixed function of the address so every delivered
// instruction can also be checked against its own PC.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b0, dmw = 1'b0, rv = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        imw, ivld;
  logic [31:0] ipc, iinst;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_hazard_stall   (hs),
    .i_data_mem_wait  (dmw),
    .i_redirect_valid (rv),
    .i_redirect_pc    (rpc),
    .imem             (bus.master),
    .o_inst_mem_wait  (imw),
    .o_if_pc          (ipc),
    .o_if_inst        (iinst),
    .o_if_valid       (ivld)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  logic [31:0] m_pc, m_dead_addr, m_held_w, m_ifpc, m_ifinst;
  bit          m_held, m_dead, m_ifv;
  // DUT outputs sampled in the most recent cycle
  logic        s_req, s_imw;
  logic [31:0] s_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = RPC; m_held = 0; m_held_w = 0; m_dead = 0; m_dead_addr = 0;
    m_ifpc = RPC; m_ifinst = NOP_INST; m_ifv = 0;
  endtask

  // Assert reset mid-cycle, check the immediate effect, release after a posedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; hs = 0; dmw = 0; rv = 0; rpc = 0; bus.ack = 0; bus.rdata = 0;
    #1;
    chk("rst_req", bus.req, 1'b0);
    chk("rst_valid", ivld, 1'b0);
    chk("rst_pc", ipc, RPC);
    chk("rst_inst", iinst, NOP_INST);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  // One clock: drive inputs, compare against model, advance model.
  task automatic cyc(input bit h, input bit d, input bit r, input logic [31:0] p, input bit a);
    bit          m_req, acked, redir, adv;
    logic [31:0] m_addr;
    @(negedge clk);
    hs = h; dmw = d; rv = r; rpc = p; bus.ack = a;
    m_req  = !m_held;
    m_addr = m_dead ? m_dead_addr : m_pc;
    bus.rdata = a ? memf(m_addr) : 32'hDEAD_BEEF;
    #1;
    s_req = bus.req; s_addr = bus.addr; s_imw = imw;
    chk("req", s_req, m_req);
    if (m_req) chk("addr", s_addr, m_addr);
    chk("imw", s_imw, m_dead || (!m_held && !a));
    chk("if_pc", ipc, m_ifpc);
    chk("if_inst", iinst, m_ifinst);
    chk("if_valid", ivld, m_ifv);
    if (ivld) chk("inst_vs_pc", iinst, memf(ipc));

    acked = m_req && a;
    redir = r && !d;
    adv   = !h && !d;
    if (redir) begin
      if (!m_held && !acked) begin
        if (!m_dead) m_dead_addr = m_pc;
        m_dead = 1;
      end else begin
        m_dead = 0;
      end
      m_held = 0;
      m_pc = p & 32'hFFFF_FFFC;
      m_ifpc = p; m_ifinst = NOP_INST; m_ifv = 0;
    end else if (m_dead) begin
      if (acked) m_dead = 0;
    end else if (m_held) begin
      if (adv) begin
        m_ifpc = m_pc; m_ifinst = m_held_w; m_ifv = 1;
        m_pc = m_pc + 32'd4; m_held = 0;
      end
    end else if (acked) begin
      if (adv) begin
        m_ifpc = m_pc; m_ifinst = memf(m_pc); m_ifv = 1;
        m_pc = m_pc + 32'd4;
      end else begin
        m_held = 1; m_held_w = memf(m_pc);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit          r_h, r_d, r_r, r_a;
    logic [31:0] r_p;
    bus.ack = 0; bus.rdata = 0;
    m_reset();
    do_reset();

    // 1: zero-wait streaming
    cyc(0, 0, 0, 0, 1);
    chk("t1_addr0", s_addr, 32'h8000_0000);
    chk("t1_valid", ivld, 1'b1);
    chk("t1_pc0", ipc, 32'h8000_0000);
    cyc(0, 0, 0, 0, 1);
    chk("t1_addr1", s_addr, 32'h8000_0004);
    cyc(0, 0, 0, 0, 1);
    chk("t1_addr2", s_addr, 32'h8000_0008);
    chk("t1_pc2", ipc, 32'h8000_0008);

    // 2: three wait cycles at 8000_0004
    do_reset();
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t2_wait", s_imw, 1'b1);
      chk("t2_pc_hold", ipc, 32'h8000_0000);
    end
    cyc(0, 0, 0, 0, 1);
    chk("t2_pc_next", ipc, 32'h8000_0004);

    // 3: stall while ack arrives -> parked word
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    chk("t3_req_low", s_req, 1'b0);
    chk("t3_pc_hold", ipc, 32'h8000_0004);
    cyc(0, 0, 0, 0, 0);
    chk("t3_held_inst", iinst, memf(32'h8000_0008));
    cyc(0, 0, 0, 0, 0);
    chk("t3_next_addr", s_addr, 32'h8000_000C);

    // 4: redirect with a transfer outstanding
    cyc(0, 0, 1, 32'h8000_0100, 0);
    chk("t4_flush", ivld, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("t4_old_addr", s_addr, 32'h8000_000C);
    chk("t4_wait", s_imw, 1'b1);
    cyc(0, 0, 0, 0, 1);
    chk("t4_dropped", ivld, 1'b0);
    cyc(0, 0, 0, 0, 1);
    chk("t4_new_addr", s_addr, 32'h8000_0100);
    chk("t4_new_pc", ipc, 32'h8000_0100);
    chk("t4_new_inst", iinst, memf(32'h8000_0100));

    // 5: redirect held through a freeze
    cyc(0, 1, 1, 32'h8000_0200, 0);
    chk("t5_frozen", ipc, 32'h8000_0100);
    cyc(0, 0, 1, 32'h8000_0200, 0);
    chk("t5_taken", ipc, 32'h8000_0200);
    chk("t5_flush", ivld, 1'b0);

    // 6: reset while discarding (reset checks inside), restart at RESET_PC
    do_reset();
    cyc(0, 0, 0, 0, 1);
    chk("t6_restart", s_addr, 32'h8000_0000);

    // random phase
    for (int n = 0; n < 3000; n++) begin
      r_h = ($urandom_range(0, 4) == 0);
      r_d = ($urandom_range(0, 5) == 0);
      r_a = ($urandom_range(0, 2) != 0);
      if (rv && dmw) begin
        r_r = 1; r_p = rpc;
      end else begin
        r_r = ($urandom_range(0, 9) == 0);
        r_p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      end
      cyc(r_h, r_d, r_r, r_p, r_a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
